// File: rtl/smm_pkg.sv
// Shared constants and FSM state type for the sparse matrix multiplier datapath.
package smm_pkg;

  localparam int SIZE_SMALL = 16;
  localparam int SIZE_LARGE = 32;
  localparam int ROW_W      = 5;
  localparam int VAL_W      = 9;
  localparam int PTR_W      = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FILL    = 2'd2,
    DRAIN   = 2'd3
  } csr_state_e;

endpackage

// File: rtl/smm_csr_pack_if.sv
// Triplet-in / CSR-out bus of the CSR repacker. No backpressure anywhere.
interface smm_csr_pack_if #(parameter int PTR_W = 11);
  import smm_pkg::*;

  logic             in_valid_size;
  logic             in_size;
  logic             in_valid;
  logic [ROW_W-1:0] in_row;
  logic [ROW_W-1:0] in_col;
  logic [VAL_W-1:0] in_val;
  logic             in_flush;
  logic             out_nz_valid;
  logic [ROW_W-1:0] out_nz_col;
  logic [VAL_W-1:0] out_nz_val;
  logic             out_ptr_valid;
  logic [PTR_W-1:0] out_ptr;
  logic             out_ptr_last;
  logic             out_err;

  modport master (
    output in_valid_size, in_size, in_valid, in_row, in_col, in_val, in_flush,
    input  out_nz_valid, out_nz_col, out_nz_val, out_ptr_valid, out_ptr,
           out_ptr_last, out_err
  );

  modport slave (
    input  in_valid_size, in_size, in_valid, in_row, in_col, in_val, in_flush,
    output out_nz_valid, out_nz_col, out_nz_val, out_ptr_valid, out_ptr,
           out_ptr_last, out_err
  );

endinterface

// File: rtl/smm_csr_ptr_rf.sv
// Row-pointer register file: one range-fill write port (every entry with
// lo <= index <= hi takes the data in the same cycle) and one async read port.
module smm_csr_ptr_rf #(
  parameter int DEPTH = 33,
  parameter int PTR_W = 11,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_lo,
  input  logic [IDX_W-1:0] wr_hi,
  input  logic [PTR_W-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [PTR_W-1:0] rd_data
);

  logic [PTR_W-1:0] mem_r [DEPTH];

  // Range fill: contents need no reset, every frame start clears them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && (IDX_W'(i) >= wr_lo) && (IDX_W'(i) <= wr_hi)) begin
        mem_r[i] <= wr_data;
      end
    end
  end

  assign rd_data = (rd_addr < IDX_W'(DEPTH)) ? mem_r[rd_addr] : {PTR_W{1'b0}};

endmodule

// File: rtl/smm_csr_pack.sv
// Repacks the row-major (row, col, val) result stream into CSR: entries are
// forwarded one cycle after input, row pointers are drained after a flush.
// Optional ordering/range checker enabled by macro SMM_CSR_CHECK_EN.
module smm_csr_pack #(
  parameter int DIM_MAX = 32,
  parameter int PTR_W   = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  smm_csr_pack_if.slave  bus
);
  import smm_pkg::*;

  localparam int               IDX_W   = $clog2(DIM_MAX + 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [PTR_W-1:0] NNZ_MAX = {PTR_W{1'b1}};

  csr_state_e       state_r, state_s;
  logic [IDX_W-1:0] n_r;
  logic [PTR_W-1:0] nnz_r;
  logic [ROW_W-1:0] cur_row_r;
  logic [IDX_W-1:0] idx_r;

  logic             start_s, accept_s, jump_s;
  logic [IDX_W-1:0] row_ext_s, col_ext_s, cur_ext_s;

  logic             wr_en_s;
  logic [IDX_W-1:0] wr_lo_s, wr_hi_s, rd_addr_s;
  logic [PTR_W-1:0] wr_data_s, rd_data_s;

  logic             nz_valid_s, ptr_valid_s, ptr_last_s;
  logic [ROW_W-1:0] nz_col_s;
  logic [VAL_W-1:0] nz_val_s;
  logic             nz_valid_r, ptr_valid_r, ptr_last_r;
  logic [ROW_W-1:0] nz_col_r;
  logic [VAL_W-1:0] nz_val_r;
  logic [PTR_W-1:0] ptr_r;

  assign start_s   = bus.in_valid_size && ((state_r == IDLE) || (state_r == COLLECT));
  assign accept_s  = bus.in_valid && (state_r == COLLECT) && !start_s;
  assign jump_s    = accept_s && (bus.in_row > cur_row_r);
  assign row_ext_s = IDX_W'(bus.in_row);
  assign col_ext_s = IDX_W'(bus.in_col);
  assign cur_ext_s = IDX_W'(cur_row_r);

  smm_csr_ptr_rf #(
    .DEPTH (DIM_MAX + 1),
    .PTR_W (PTR_W),
    .IDX_W (IDX_W)
  ) u_ptr_rf (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_lo   (wr_lo_s),
    .wr_hi   (wr_hi_s),
    .wr_data (wr_data_s),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a size strobe in COLLECT restarts the frame.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_s = COLLECT;
        else         state_s = IDLE;
      end
      COLLECT: begin
        if (start_s)           state_s = COLLECT;
        else if (bus.in_flush) state_s = FILL;
        else                   state_s = COLLECT;
      end
      FILL: state_s = DRAIN;
      DRAIN: begin
        if (idx_r == n_r) state_s = IDLE;
        else              state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output/control logic: pointer-file writes and next values of the outputs.
  // ptr[0] is never written after the clear, so FILL can already emit it;
  // DRAIN then reads ptr[1..N] and the registered outputs land on the
  // flush+2 .. flush+2+N window.
  always_comb begin
    wr_en_s     = 1'b0;
    wr_lo_s     = {IDX_W{1'b0}};
    wr_hi_s     = {IDX_W{1'b0}};
    wr_data_s   = {PTR_W{1'b0}};
    rd_addr_s   = idx_r;
    ptr_valid_s = 1'b0;
    ptr_last_s  = 1'b0;
    nz_valid_s  = accept_s;
    nz_col_s    = bus.in_col;
    nz_val_s    = bus.in_val;
    case (state_r)
      IDLE, COLLECT: begin
        if (start_s) begin
          wr_en_s = 1'b1;
          wr_hi_s = IDX_W'(DIM_MAX);
        end else if (jump_s) begin
          wr_en_s   = 1'b1;
          wr_lo_s   = cur_ext_s + IDX_ONE;
          wr_hi_s   = row_ext_s;
          wr_data_s = nnz_r;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      FILL: begin
        wr_en_s     = 1'b1;
        wr_lo_s     = cur_ext_s + IDX_ONE;
        wr_hi_s     = n_r;
        wr_data_s   = nnz_r;
        rd_addr_s   = {IDX_W{1'b0}};
        ptr_valid_s = 1'b1;
      end
      DRAIN: begin
        ptr_valid_s = 1'b1;
        ptr_last_s  = (idx_r == n_r);
      end
      default: begin
        ptr_valid_s = 1'b0;
      end
    endcase
  end

  // Frame counters: dimension, saturating nonzero count, current row, drain index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_r       <= IDX_W'(SIZE_SMALL);
      nnz_r     <= {PTR_W{1'b0}};
      cur_row_r <= {ROW_W{1'b0}};
      idx_r     <= {IDX_W{1'b0}};
    end else if (start_s) begin
      n_r       <= bus.in_size ? IDX_W'(SIZE_LARGE) : IDX_W'(SIZE_SMALL);
      nnz_r     <= {PTR_W{1'b0}};
      cur_row_r <= {ROW_W{1'b0}};
      idx_r     <= {IDX_W{1'b0}};
    end else if (accept_s) begin
      if (nnz_r != NNZ_MAX) nnz_r <= nnz_r + {{(PTR_W-1){1'b0}}, 1'b1};
      if (jump_s) cur_row_r <= bus.in_row;
    end else if (state_r == FILL) begin
      idx_r <= IDX_ONE;
    end else if (state_r == DRAIN) begin
      idx_r <= idx_r + IDX_ONE;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nz_valid_r  <= 1'b0;
      nz_col_r    <= {ROW_W{1'b0}};
      nz_val_r    <= {VAL_W{1'b0}};
      ptr_valid_r <= 1'b0;
      ptr_r       <= {PTR_W{1'b0}};
      ptr_last_r  <= 1'b0;
    end else begin
      nz_valid_r  <= nz_valid_s;
      nz_col_r    <= nz_valid_s ? nz_col_s : {ROW_W{1'b0}};
      nz_val_r    <= nz_valid_s ? nz_val_s : {VAL_W{1'b0}};
      ptr_valid_r <= ptr_valid_s;
      ptr_r       <= ptr_valid_s ? rd_data_s : {PTR_W{1'b0}};
      ptr_last_r  <= ptr_last_s;
    end
  end

  assign bus.out_nz_valid  = nz_valid_r;
  assign bus.out_nz_col    = nz_col_r;
  assign bus.out_nz_val    = nz_val_r;
  assign bus.out_ptr_valid = ptr_valid_r;
  assign bus.out_ptr       = ptr_r;
  assign bus.out_ptr_last  = ptr_last_r;

`ifdef SMM_CSR_CHECK_EN
  logic [ROW_W-1:0] last_col_r;
  logic             last_col_vld_r;
  logic             err_r;
  logic             bad_s;

  // Offending triplet: row going backwards, out of range, or column not increasing.
  always_comb begin
    bad_s = 1'b0;
    if (accept_s) begin
      bad_s = (bus.in_row < cur_row_r) || (row_ext_s >= n_r) || (col_ext_s >= n_r) ||
              ((bus.in_row == cur_row_r) && last_col_vld_r && (bus.in_col <= last_col_r));
    end else begin
      bad_s = 1'b0;
    end
  end

  // Sticky error flag and last column seen in the current row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r          <= 1'b0;
      last_col_r     <= {ROW_W{1'b0}};
      last_col_vld_r <= 1'b0;
    end else if (start_s) begin
      err_r          <= 1'b0;
      last_col_r     <= {ROW_W{1'b0}};
      last_col_vld_r <= 1'b0;
    end else begin
      err_r <= err_r | bad_s;
      if (accept_s && (bus.in_row >= cur_row_r)) begin
        last_col_r     <= bus.in_col;
        last_col_vld_r <= 1'b1;
      end
    end
  end

  assign bus.out_err = err_r;
`else
  assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_smm_csr_pack.sv
// Scoreboard bench for smm_csr_pack: stimulus pushes expected entries and
// pointers (value + exact cycle), a negedge monitor pops and compares.
module tb_smm_csr_pack;

`ifdef SMM_CSR_CHECK_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  typedef struct {
    int col;
    int val;
    int cyc;
  } nz_t;

  typedef struct {
    int ptr;
    int last;
    int cyc;
  } ptr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   n_cur = 16;
  int   tid_cur = 0;
  nz_t  nz_q[$];
  ptr_t ptr_q[$];

  smm_csr_pack_if #(.PTR_W(11)) bus ();

  smm_csr_pack #(.DIM_MAX(32), .PTR_W(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Hand-derived CSR row pointers for each directed frame.
  function automatic int exp_ptr(input int tid, input int k);
    case (tid)
      1: return (k == 0) ? 0 : ((k <= 2) ? 2 : 3);
      2: return 0;
      3: return (k == 32) ? 1 : 0;
      4: return 16 * k;
      5: return (k <= 3) ? 0 : 2;
      6: return (k <= 5) ? 0 : 1;
      default: return -1;
    endcase
  endfunction

  // Monitor: pop and compare whenever the DUT presents an output.
  always @(negedge clk) begin
    if (bus.out_nz_valid) begin
      if (nz_q.size() == 0) begin
        check("nz_unexpected", 1, 0);
      end else begin
        nz_t e;
        e = nz_q.pop_front();
        check("nz_col", int'(bus.out_nz_col), e.col);
        check("nz_val", int'(bus.out_nz_val), e.val);
        check("nz_cycle", cyc, e.cyc);
      end
    end
    if (bus.out_ptr_valid) begin
      if (ptr_q.size() == 0) begin
        check("ptr_unexpected", 1, 0);
      end else begin
        ptr_t p;
        p = ptr_q.pop_front();
        check("ptr_val", int'(bus.out_ptr), p.ptr);
        check("ptr_last", int'(bus.out_ptr_last), p.last);
        check("ptr_cycle", cyc, p.cyc);
      end
    end else if (bus.out_ptr_last) begin
      check("ptr_last_without_valid", 1, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ptrs(input int tid, input int nn, input int fcyc);
    for (int k = 0; k <= nn; k++) begin
      ptr_q.push_back('{ptr: exp_ptr(tid, k), last: (k == nn) ? 1 : 0, cyc: fcyc + 2 + k});
    end
  endtask

  task automatic begin_frame(input int size, input int tid);
    bus.in_valid_size = 1'b1;
    bus.in_size = size[0];
    n_cur = (size != 0) ? 32 : 16;
    tid_cur = tid;
    tick();
    bus.in_valid_size = 1'b0;
    bus.in_size = 1'b0;
  endtask

  task automatic send(input int r, input int c, input int v, input bit fl, input bit exp);
    bus.in_valid = 1'b1;
    bus.in_row = 5'(r);
    bus.in_col = 5'(c);
    bus.in_val = 9'(v);
    bus.in_flush = fl;
    if (exp) nz_q.push_back('{col: c, val: v, cyc: cyc + 1});
    if (fl) push_ptrs(tid_cur, n_cur, cyc);
    tick();
    bus.in_valid = 1'b0;
    bus.in_flush = 1'b0;
  endtask

  task automatic flush();
    bus.in_flush = 1'b1;
    push_ptrs(tid_cur, n_cur, cyc);
    tick();
    bus.in_flush = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && (ptr_q.size() != 0 || nz_q.size() != 0); i++) tick();
    check("drain_timeout", ptr_q.size() + nz_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, int'(bus.out_nz_valid) + int'(bus.out_nz_col) + int'(bus.out_nz_val) +
          int'(bus.out_ptr_valid) + int'(bus.out_ptr) + int'(bus.out_ptr_last) +
          int'(bus.out_err), 0);
  endtask

  initial begin
    bus.in_valid_size = 1'b0;
    bus.in_size = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_row = 5'd0;
    bus.in_col = 5'd0;
    bus.in_val = 9'd0;
    bus.in_flush = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset_outputs");
    rst_n = 1'b1;
    tick();

    // Triplets and flush while IDLE are dropped.
    send(1, 2, 3, 1'b1, 1'b0);
    ptr_q.delete();
    check("idle_drop_nz", int'(bus.out_nz_valid), 0);
    tick();
    check("idle_drop_ptr", int'(bus.out_ptr_valid), 0);

    // Frame 1: N=16, three triplets.
    begin_frame(0, 1);
    send(0, 1, 5, 1'b0, 1'b1);
    send(0, 3, 7, 1'b0, 1'b1);
    send(2, 0, 9, 1'b0, 1'b1);
    flush();
    wait_drain();

    // Frame 2: N=32, empty flush.
    begin_frame(1, 2);
    flush();
    wait_drain();

    // Frame 3: N=32, single triplet coinciding with the flush.
    begin_frame(1, 3);
    send(31, 31, 511, 1'b1, 1'b1);
    wait_drain();

    // Frame 4: dense 16x16, back-to-back.
    begin_frame(0, 4);
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        send(i, j, (i * 16 + j) % 512, 1'b0, 1'b1);
      end
    end
    flush();
    wait_drain();

    // Frame 5: row goes backwards; still forwarded and counted.
    begin_frame(0, 5);
    send(3, 2, 11, 1'b0, 1'b1);
    check("err_before", int'(bus.out_err), 0);
    send(1, 0, 12, 1'b0, 1'b1);
    check("err_set", int'(bus.out_err), ERR_EN);
    flush();
    repeat (4) tick();
    check("err_held_drain", int'(bus.out_err), ERR_EN);
    wait_drain();
    check("err_held_idle", int'(bus.out_err), ERR_EN);
    begin_frame(0, 2);
    check("err_cleared", int'(bus.out_err), 0);
    flush();
    wait_drain();

    // Frame 6: reset mid-DRAIN, then a clean frame.
    begin_frame(0, 6);
    send(5, 4, 3, 1'b0, 1'b1);
    flush();
    repeat (4) tick();
    check("drain_active", int'(bus.out_ptr_valid), 1);
    rst_n = 1'b0;
    tick();
    ptr_q.delete();
    check_outputs_zero("reset_mid_drain");
    rst_n = 1'b1;
    tick();
    begin_frame(0, 1);
    send(0, 1, 5, 1'b0, 1'b1);
    send(0, 3, 7, 1'b0, 1'b1);
    send(2, 0, 9, 1'b0, 1'b1);
    flush();
    wait_drain();
    repeat (3) tick();
    check("final_idle", int'(bus.out_ptr_valid) + int'(bus.out_nz_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/smm_csr_pack.md
# smm_csr_pack

Downstream stage of the sparse matrix multiplier. Consumes the multiplier's result triplet stream (row, col, val), which arrives in row-major order, and repacks it into CSR form. Each nonzero is forwarded as a (col, val) entry with one cycle of latency. When the frame is flushed, the block emits the N+1 row-pointer values. The result feeds the writeback/compare logic, which expects CSR.

## Interface
- `DIM_MAX`, default 32: largest supported matrix dimension; sets the row-pointer array depth to DIM_MAX+1.
- `PTR_W`, default 11: row-pointer/nonzero-count width; holds 0..DIM_MAX².
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid_size` in 1: frame-start strobe, shared with the multiplier.
- `in_size` in 1: dimension select; 0 → N=16, 1 → N=32; sampled with `in_valid_size`.
- `in_valid` in 1: result triplet valid (multiplier `out_valid`).
- `in_row` in 5: result row.
- `in_col` in 5: result column.
- `in_val` in 9: result value.
- `in_flush` in 1: one-cycle pulse; the frame's triplets are complete.
- `out_nz_valid` out 1: forwarded entry valid.
- `out_nz_col` out 5: forwarded column.
- `out_nz_val` out 9: forwarded value.
- `out_ptr_valid` out 1: row-pointer valid.
- `out_ptr` out PTR_W: row-pointer value.
- `out_ptr_last` out 1: asserted with ptr[N].
- `out_err` out 1: sticky ordering/range error (only with the macro).

## Operation
- FSM states: IDLE, COLLECT, FILL, DRAIN.
- IDLE → COLLECT on `in_valid_size`:
  - latch N;
  - clear nnz count, cur_row=0, last_col=none, all pointers;
  - clear `out_err`.
- `in_valid_size` in COLLECT restarts the frame identically. It is ignored in FILL and DRAIN.
- COLLECT, `in_valid` with row r:
  - if r > cur_row, write ptr[i]=nnz for every i with cur_row < i ≤ r, all in the same cycle; then cur_row=r.
  - nnz increments by 1 and saturates at 2^PTR_W−1.
  - ptr[0] is always 0.
- Every accepted triplet is forwarded as an entry (col, val), including val=0.
- `in_valid` outside COLLECT is dropped and not forwarded.
- `in_flush` in COLLECT → FILL. If `in_valid` coincides with `in_flush`, that triplet is counted first.
- FILL (1 cycle): ptr[i]=nnz for cur_row < i ≤ N; then go to DRAIN with index=0.
- DRAIN: emit ptr[index] and increment index. At index=N assert `out_ptr_last`, then go to IDLE.
- A flush with no triplets yields N+1 zeros.
- `in_flush` outside COLLECT is ignored.
- Reset mid-frame: immediately IDLE; all outputs go to reset values; pointer contents are don't-care.

## Timing
- Reset values: every output 0; state IDLE.
- Entry latency: `in_valid` at cycle t → `out_nz_*` at t+1. One entry per cycle, back-to-back, with no stalls.
- Flush at cycle t → FILL at t+1 → `out_ptr_valid` high for cycles t+2 .. t+2+N, contiguous.
- `out_ptr_last` is high only at t+2+N.
- There is no backpressure on any port. The downstream stage must accept every cycle.

## Configuration
- Macro `SMM_CSR_CHECK_EN`.
- Defined: `out_err` is set, one cycle after the offending triplet, when any of these holds:
  - r < cur_row;
  - r ≥ N or col ≥ N;
  - r == cur_row and col ≤ the previous column in that row.
- In every error case the triplet is still forwarded and counted. `out_err` holds until the next frame start or reset.
- Undefined: no checking logic; `out_err` is tied to 0. The port is always present.

## Structure
- Shared package `smm_pkg` holds:
  - `SIZE_SMALL=16` and `SIZE_LARGE=32`;
  - `ROW_W=5`, `VAL_W=9`, `PTR_W`;
  - the FSM state enum.
- The multiplier's ports use the same package constants.
- One sub-module, `smm_csr_ptr_rf`: the DIM_MAX+1 × PTR_W pointer register file with range-fill write (lo, hi, data) and one read port. The FSM, counters and checker live in the top.

## Test plan
- in_size=0; triplets (0,1,5), (0,3,7), (2,0,9); flush → entries (1,5), (3,7), (0,9) each 1 cycle after input; pointers 0,2,2,3,…,3 (17 values); last asserted on the 17th.
- in_size=1; flush with no triplets → 33 zeros on consecutive cycles starting 2 cycles after flush.
- in_size=1; single triplet (31,31,511) with `in_flush` in the same cycle → ptr[0..31]=0, ptr[32]=1.
- Full 16×16 dense stream, 256 triplets back-to-back → ptr[i]=16·i; nnz=256 at flush; no dropped entries.
- With `SMM_CSR_CHECK_EN`: triplets (3,2), (1,0) → `out_err`=1 one cycle after (1,0) and held through DRAIN; cleared by the next `in_valid_size`.
- Reset asserted mid-DRAIN → all outputs 0 the next cycle. A new frame then runs correctly.
